// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_test_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int ERR_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Expected response of an ideal 3-input AND gate for stimulus v = {x,y,z}.
    function automatic logic and3(input logic [VEC_W-1:0] v);
        return &v;
    endfunction

endpackage

// File: rtl/gate_test_seq.sv
// gate_test_seq: walks all eight {x,y,z} vectors into a 3-input AND gate,
// holds each for SETTLE cycles, samples r for one cycle and counts mismatches.
// Optional first-failure capture is enabled with GATE_TEST_SEQ_FAIL_CAPTURE_EN;
// without it fail_vec is tied to 0.
//
// Handshake: start is level-sampled only in IDLE (abort has priority there);
// busy is high in DRIVE/CHECK; done is a one-cycle pulse in DONE, during which
// pass and err_cnt already carry the final result of the pass.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] fail_vec,
    output state_t           fsm_state
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t             state, state_next;
    logic [VEC_W-1:0]   vec, vec_next;
    logic [3:0]         settle_cnt, settle_next;
    logic [ERR_W-1:0]   err_next;
    logic               pass_next;
    logic [VEC_W-1:0]   stim_next;
    logic               accept;
    logic               mismatch;
    logic               capture;

    // Next-state, datapath updates and decoded outputs.
    always_comb begin
        state_next  = state;
        vec_next    = vec;
        settle_next = settle_cnt;
        err_next    = err_cnt;
        pass_next   = pass;
        accept      = 1'b0;
        mismatch    = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next  = DRIVE;
                    vec_next    = '0;
                    settle_next = '0;
                    err_next    = '0;
                    pass_next   = 1'b0;
                    accept      = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_next = IDLE;
                    pass_next  = 1'b0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next  = CHECK;
                    settle_next = '0;
                end else begin
                    settle_next = settle_cnt + 4'd1;
                end
            end
            CHECK: begin
                mismatch = (r != and3({x, y, z}));
                if (abort) begin
                    // Partial count is kept; the aborted sample is not scored.
                    state_next = IDLE;
                    pass_next  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_next = err_cnt + ERR_W'(1);
                        capture  = (err_cnt == '0);
                    end
                    if (vec == VEC_W'(NUM_VEC - 1)) begin
                        state_next = DONE;
                        pass_next  = (err_next == '0);
                    end else begin
                        state_next = DRIVE;
                        vec_next   = vec + VEC_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Stimulus follows the vector only while a pass is in progress.
        stim_next = ((state_next == DRIVE) || (state_next == CHECK)) ? vec_next : '0;
    end

    // State, vector, settle counter, result and stimulus registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            pass       <= 1'b0;
            x          <= 1'b0;
            y          <= 1'b0;
            z          <= 1'b0;
        end else begin
            state      <= state_next;
            vec        <= vec_next;
            settle_cnt <= settle_next;
            err_cnt    <= err_next;
            pass       <= pass_next;
            x          <= stim_next[2];
            y          <= stim_next[1];
            z          <= stim_next[0];
        end
    end

`ifdef GATE_TEST_SEQ_FAIL_CAPTURE_EN
    logic [VEC_W-1:0] fail_q;

    // First-mismatch capture, cleared when a new pass is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= '0;
        end else if (accept) begin
            fail_q <= '0;
        end else if (capture) begin
            fail_q <= vec;
        end
    end

    assign fail_vec = fail_q;
`else
    logic unused_capture;
    assign unused_capture = capture ^ accept;
    assign fail_vec       = '0;
`endif

    assign busy      = (state == DRIVE) || (state == CHECK);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: an AND gate model sits beside the DUT with
// selectable ideal / stuck-at-0 / stuck-at-1 behaviour.
module tb_gate_test_seq;
    import gate_test_pkg::*;

    localparam int SETTLE = 2;
    localparam int LAT    = NUM_VEC * (SETTLE + 1) + 1;
    localparam int W      = 24;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic r;
    logic x, y, z, busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
    logic [VEC_W-1:0] fail_vec;
    state_t fsm_state;
    logic [1:0] gate_mode = 2'd0;   // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test, beside the sequencer.
    assign r = (gate_mode == 2'd0) ? (x & y & z) : (gate_mode == 2'd2);

    gate_test_seq #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .x         (x),
        .y         (y),
        .z         (z),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_vec  (fail_vec),
        .fsm_state (fsm_state)
    );

`ifdef GATE_TEST_SEQ_FAIL_CAPTURE_EN
    localparam logic [2:0] FV_STUCK0 = 3'b111;
`else
    localparam logic [2:0] FV_STUCK0 = 3'b000;
`endif

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_item;
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack(input int dc, input int e_err, input logic e_pass,
                                          input logic [2:0] e_fv);
        logic [15:0] c16;
        logic [3:0]  e4;
        c16 = dc[15:0];
        e4  = e_err[3:0];
        return {c16, e4, e_pass, e_fv};
    endfunction

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_item = exp_q.pop_front();
                check("done_cycle", 32'(cyc[15:0]), 32'(mon_item[23:8]));
                check("done_err_cnt", 32'(err_cnt), 32'(mon_item[7:4]));
                check("done_pass", 32'(pass), 32'(mon_item[3]));
                check("done_fail_vec", 32'(fail_vec), 32'(mon_item[2:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_pass(input logic [1:0] mode, input bit expect_done, input int e_err,
                              input logic e_pass, input logic [2:0] e_fv, output int cs);
        @(negedge clk);
        gate_mode = mode;
        start     = 1'b1;
        cs        = cyc;
        if (expect_done) exp_q.push_back(pack(cs + LAT, e_err, e_pass, e_fv));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_vectors(input int cs, input int upto);
        for (int k = 0; k < upto; k++) begin
            wait_until(cs + 1 + k * (SETTLE + 1) + SETTLE);
            check("xyz_in_check", 32'({x, y, z}), 32'(k));
            check("busy_in_check", 32'(busy), 32'd1);
        end
    endtask

    task automatic finish_pass(input int cs);
        wait_until(cs + LAT + 1);
        check("idle_after_done", 32'(fsm_state), 32'(IDLE));
        check("busy_after_done", 32'(busy), 32'd0);
        check("xyz_after_done", 32'({x, y, z}), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cs;
        int cs2;

        // Reset state, asserted from time 0.
        #1;
        check("reset_outputs", 32'({x, y, z, busy, done, pass, err_cnt, fail_vec}), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ideal gate: clean pass, done LAT cycles after the start cycle.
        start_pass(2'd0, 1'b1, 0, 1'b1, 3'b000, cs);
        check_vectors(cs, NUM_VEC);
        finish_pass(cs);
        wait_until(cyc + 3);
        check("hold_pass_idle", 32'(pass), 32'd1);
        check("hold_err_idle", 32'(err_cnt), 32'd0);

        // Stuck-at-0: only vector 7 mismatches.
        start_pass(2'd1, 1'b1, 1, 1'b0, FV_STUCK0, cs);
        check_vectors(cs, NUM_VEC);
        finish_pass(cs);
        wait_until(cyc + 2);
        check("hold_err_stuck0", 32'(err_cnt), 32'd1);
        check("hold_fail_vec_stuck0", 32'(fail_vec), 32'(FV_STUCK0));

        // Stuck-at-1: vectors 0..6 mismatch, first failure is 000.
        start_pass(2'd2, 1'b1, 7, 1'b0, 3'b000, cs);
        finish_pass(cs);

        // Abort during the first DRIVE cycle of vector 4 (stuck-at-1: 4 errors so far).
        start_pass(2'd2, 1'b0, 0, 1'b0, 3'b000, cs);
        wait_until(cs + 1 + 4 * (SETTLE + 1));
        check("abort_xyz_before", 32'({x, y, z}), 32'd4);
        check("abort_err_before", 32'(err_cnt), 32'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", 32'(fsm_state), 32'(IDLE));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_err_partial", 32'(err_cnt), 32'd4);
        check("abort_xyz", 32'({x, y, z}), 32'd0);
        wait_until(cyc + 3);
        check("abort_stays_idle", 32'(fsm_state), 32'(IDLE));

        // Start together with abort in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", 32'(fsm_state), 32'(IDLE));

        // Clean pass after abort.
        start_pass(2'd0, 1'b1, 0, 1'b1, 3'b000, cs);
        check_vectors(cs, NUM_VEC);
        finish_pass(cs);

        // Reset mid-pass for one cycle, then start on the first edge after release.
        start_pass(2'd1, 1'b0, 0, 1'b0, 3'b000, cs);
        wait_until(cs + 7);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({x, y, z, busy, done, pass, err_cnt, fail_vec}), 32'd0);
        check("midreset_state", 32'(fsm_state), 32'(IDLE));
        @(negedge clk);
        rst_n     = 1'b1;
        gate_mode = 2'd0;
        start     = 1'b1;
        cs2       = cyc;
        exp_q.push_back(pack(cs2 + LAT, 0, 1'b1, 3'b000));
        @(negedge clk);
        start = 1'b0;
        check("release_accept_state", 32'(fsm_state), 32'(DRIVE));
        check("release_accept_busy", 32'(busy), 32'd1);
        check_vectors(cs2, NUM_VEC);
        finish_pass(cs2);

        // Start held across two passes.
        @(negedge clk);
        gate_mode = 2'd0;
        start     = 1'b1;
        cs        = cyc;
        exp_q.push_back(pack(cs + LAT, 0, 1'b1, 3'b000));
        exp_q.push_back(pack(cs + 2 * LAT + 1, 0, 1'b1, 3'b000));
        check_vectors(cs, NUM_VEC);
        wait_until(cs + LAT + 1);
        check("held_start_idle_gap", 32'(fsm_state), 32'(IDLE));
        check("held_start_busy_gap", 32'(busy), 32'd0);
        wait_until(cs + LAT + 2);
        check("held_start_second", 32'(fsm_state), 32'(DRIVE));
        start = 1'b0;
        check_vectors(cs + LAT + 1, NUM_VEC);
        finish_pass(cs + LAT + 1);

        repeat (5) @(negedge clk);
        check("pending_done_count", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 SETTLE, default 2, meaning number of cycles each input vector is held before r is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  level-sampled request to run one full test pass; acted on only in IDLE.
REQ-005 abort  input  1  terminates a running pass and returns to IDLE.
REQ-006 x, y, z  output  1 each  registered stimulus driven to the 3-input AND gate under test.
REQ-007 r  input  1  result returned by the gate under test.
REQ-008 busy  output  1  high in every state except IDLE and DONE.
REQ-009 done  output  1  one-cycle pulse at the end of a completed pass.
REQ-010 pass  output  1  high when the last completed pass had zero mismatches.
REQ-011 err_cnt  output  4  mismatch count for the current or last pass, range 0..8.
REQ-012 fail_vec  output  3  {x,y,z} of the first failing vector; present only with the REQ-030 macro.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, CHECK and DONE.
REQ-014 In IDLE with start=1 and abort=0, the next state SHALL be DRIVE, with vec=0, err_cnt cleared and pass cleared.
REQ-015 {x,y,z} SHALL equal vec[2:0] registered, with x as the MSB, throughout DRIVE and CHECK.
REQ-016 DRIVE SHALL last exactly SETTLE cycles, counted by a 4-bit settle counter, and then go to CHECK.
REQ-017 CHECK SHALL last 1 cycle and SHALL compare r against expected = x&y&z.
REQ-018 On a mismatch in CHECK, err_cnt SHALL increment by 1; no saturation is needed because the maximum is 8.
REQ-019 On leaving CHECK: if vec==7 the next state SHALL be DONE, otherwise vec SHALL increment and the next state SHALL be DRIVE.
REQ-020 DONE SHALL last 1 cycle with done=1 and pass=(err_cnt==0), then go to IDLE.
REQ-021 pass and err_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-022 Total latency from the start-accept edge to done high SHALL be 8*(SETTLE+1)+1 cycles, which is 25 cycles for SETTLE=2.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 abort=1 in DRIVE or CHECK SHALL return the FSM to IDLE on the next edge with done=0, pass=0, err_cnt holding its partial count, and x,y,z=0.
REQ-025 If start and abort are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-026 In IDLE, x, y and z SHALL be 0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, vec=0, settle counter=0, x=y=z=0, busy=0, done=0, pass=0, err_cnt=0 and fail_vec=0.
REQ-028 Reset asserted mid-pass SHALL discard the pass; no done pulse SHALL follow reset release.
REQ-029 After release, the first start SHALL be accepted on the first rising edge where rst_n=1.

Configuration
REQ-030 Macro GATE_TEST_SEQ_FAIL_CAPTURE_EN.
- Defined: fail_vec SHALL latch vec in the CHECK cycle of the first mismatch of a pass, and SHALL clear on start-accept.
- Undefined: fail_vec SHALL be a constant 0 and no capture register SHALL exist.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-031 Shared package gate_test_pkg SHALL hold the state typedef (IDLE, DRIVE, CHECK, DONE), VEC_W=3, NUM_VEC=8, ERR_W=4 and the expected-value function and3(vec).
REQ-032 The block SHALL be a single flat module with no sub-module; the gate under test SHALL be instantiated beside it, not inside it.

Verification
REQ-033 With an ideal AND gate, SETTLE=2 and a 1-cycle start pulse, the bench SHALL see done 25 cycles later, err_cnt=0 and pass=1.
REQ-034 With r stuck at 0, the bench SHALL see err_cnt=1, pass=0 and fail_vec=3'b111 (macro on), or fail_vec=0 (macro off).
REQ-035 With r stuck at 1, the bench SHALL see err_cnt=7, pass=0 and fail_vec=3'b000.
REQ-036 With abort asserted during the DRIVE of vec=4, the bench SHALL see IDLE next cycle, no done pulse, x=y=z=0, and a subsequent start running a full clean pass.
REQ-037 With rst_n low for 1 cycle mid-pass, the bench SHALL see all outputs 0 immediately, no done pulse, and start-accept on the first edge after release.
REQ-038 With start held high continuously across two passes, the bench SHALL see start ignored while busy and the second pass beginning in the cycle after DONE returns to IDLE.
